wasm_frame_stack: RTL and testbench
===================================

// Module: wasm_frame_stack
// PURPOSE
//  Parametrised operand/locals stack for the WASM core, with call-frame management.
//  Holds operands and per-call locals in one RAM. Keeps a frame LIFO of {fp,sb}.
//  On call, locals are zeroed over several cycles; on return, results are copied over several cycles.
//  Sits between decode and the ALU: provides WIN pop windows, local get/set and sticky error flags.
// PARAMETERS
//  WIDTH   32   stack word width
//  DEPTH   256  stack RAM entries; AW = $clog2(DEPTH)
//  FRAMES  16   frame LIFO entries (max call nesting)
//  WIN     3    pop-window count (ALU operand taps)
// PORTS
//  clk             in   1          clock
//  rst_n           in   1          reset, asynchronous, active-low
//  op_valid        in   1          op present this cycle
//  op_ready        out  1          high in IDLE only; op accepted = op_valid & op_ready
//  pop_num         in   4          operands popped
//  push_en         in   1          push push_data after the pop
//  push_data       in   WIDTH      pushed value
//  call_en         in   1          call: top call_nargs operands become locals 0..nargs-1
//  call_nargs      in   8          argument count
//  call_nlocals    in   8          total locals (args included)
//  ret_en          in   1          return: keep top ret_nres words as results
//  ret_nres        in   4          result count
//  local_addr      in   AW         frame-relative local index
//  local_set       in   1          write local_set_data to local
//  local_set_data  in   WIDTH      local write data
//  local_get_data  out  WIDTH      mem[fp+local_addr], combinational
//  pop_win         out  WIN*WIDTH  slot k = mem[sp-1-k] if sp-1-k >= sb, else 0
//  sp, fp, sb      out  AW+1 each  top, frame base, operand base
//  frame_depth     out  $clog2(FRAMES+1)  live frames
//  err_underflow, err_overflow, err_frame  out 1  sticky until err_clear
//  err_clear       in   1          clears all sticky errors
// BEHAVIOUR
//  Reset: sp=fp=sb=0, frame_depth=0, errors=0, FSM=IDLE, op_ready=1. RAM contents are not reset.
//  Reset mid-ZERO/RET_COPY aborts the operation immediately.
//  Op priority on accept: ret > call > local_set > pop/push. call_en&ret_en together: set err_frame, drop op.
//  Pop/push, 1 cycle:
//   - Underflow if pop_num > sp-sb: set err_underflow, drop op.
//   - Overflow if sp-pop_num+push_en > DEPTH: set err_overflow, drop op.
//   - Otherwise sp <= sp-pop_num+push_en; push writes mem[sp-pop_num].
//   - A dropped op leaves pointers and RAM unchanged.
//  local_set: mem[fp+local_addr] <= data; no pointer change.
//  Call:
//   - err_frame if nargs>nlocals or frame_depth==FRAMES.
//   - err_underflow if nargs>sp-sb. err_overflow if sp-nargs+nlocals>DEPTH.
//   - Otherwise: push {fp,sb}; fp <= sp-nargs; sb <= fp_new+nlocals.
//   - Then ZERO state, nlocals-nargs cycles, writes 0 at fp_new+nargs.. ascending.
//   - sp <= sb at ZERO exit. Zero-length ZERO returns to IDLE next cycle.
//  Return:
//   - err_frame if frame_depth==0. err_underflow if nres>sp-sb.
//   - Otherwise RET_COPY, nres cycles: mem[fp+i] <= mem[sp-nres+i], i ascending (safe, dst<=src).
//   - At exit: sp <= fp+nres; {fp,sb} <= popped frame. nres==0 commits after 1 cycle.
//  FSM: IDLE -> ZERO | RET_COPY -> IDLE; op_ready=0 outside IDLE; inputs ignored.
//  Pointer arithmetic is AW+1 bits, unsigned; comparisons are done before subtraction, so no wrap.
//  Sticky set in the same cycle as err_clear wins (set).
// CONFIGURATION
//  WFS_BOUNDS_CHECK_EN defined:
//   - local_addr >= sb-fp sets err_frame.
//   - local_set is suppressed; local_get_data = 0.
//  Not defined: no check; physical address fp+local_addr taken mod DEPTH.
// STRUCTURE
//  wasm_stack_pkg: AW/FW localparam helpers; frame_t {fp,sb}; state_e {IDLE,ZERO,RET_COPY}.
//  Sub-module wfs_frame_lifo:
//   - FRAMES x frame_t register LIFO with push/pop/depth/full/empty.
//   - Async reset to empty.
//  Top: RAM, pointer regs, FSM + copy/zero counter, error logic.
// TESTING
//  1 push 5,7,9 -> sp=3, pop_win={9,7,5}; then pop_num=2+push 16 -> sp=2, slot0=16, slot1=5, slot2=0
//  2 pop_num=1 at sp=0 -> err_underflow=1, sp=0; err_clear -> 0
//  3 stack {1,2,3}; call nargs=2 nlocals=4 -> fp=1, op_ready low 2 cycles, sb=sp=5, locals 2,3,0,0
//  4 after 3, push 42, ret nres=1 -> 1 copy cycle, sp=2, mem[1]=42, fp=0, sb=0, frame_depth=0
//  5 FRAMES nested calls ok, next call -> err_frame, depth=FRAMES; ret at depth 0 -> err_frame
//  6 rst_n low mid-ZERO -> same cycle op_ready=1, sp=fp=sb=0, frame_depth=0

Source files
------------

// File: rtl/wasm_stack_pkg.sv
// wasm_stack_pkg: shared sizing helpers and types for the wasm_frame_stack slice
//   aw_of(depth)  : address width of a stack RAM with depth entries
//   fw_of(frames) : width of a live-frame counter that can reach frames
//   frame_t       : saved {fp,sb} record, sized for the default 256-entry stack
//   state_e       : sequencer states IDLE / ZERO / RET_COPY
package wasm_stack_pkg;

    localparam int DEPTH_DEF = 256;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int fw_of(input int frames);
        return $clog2(frames + 1);
    endfunction

    typedef struct packed {
        logic [aw_of(DEPTH_DEF):0] fp;
        logic [aw_of(DEPTH_DEF):0] sb;
    } frame_t;

    typedef enum logic [1:0] {IDLE, ZERO, RET_COPY} state_e;

endpackage

// File: rtl/wasm_frame_stack_if.sv
// wasm_frame_stack_if: decode-side bundle of the frame stack
//   master : decode (drives op_valid, pop/push, call, ret, local access, err_clear)
//   slave  : stack (drives op_ready, local_get_data, pop_win, sp/fp/sb, frame_depth, errors)
interface wasm_frame_stack_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int FRAMES = 16,
    parameter int WIN    = 3
);
    import wasm_stack_pkg::*;

    localparam int AW = aw_of(DEPTH);
    localparam int FW = fw_of(FRAMES);

    logic                 op_valid;
    logic                 op_ready;
    logic [3:0]           pop_num;
    logic                 push_en;
    logic [WIDTH-1:0]     push_data;
    logic                 call_en;
    logic [7:0]           call_nargs;
    logic [7:0]           call_nlocals;
    logic                 ret_en;
    logic [3:0]           ret_nres;
    logic [AW-1:0]        local_addr;
    logic                 local_set;
    logic [WIDTH-1:0]     local_set_data;
    logic [WIDTH-1:0]     local_get_data;
    logic [WIN*WIDTH-1:0] pop_win;
    logic [AW:0]          sp;
    logic [AW:0]          fp;
    logic [AW:0]          sb;
    logic [FW-1:0]        frame_depth;
    logic                 err_underflow;
    logic                 err_overflow;
    logic                 err_frame;
    logic                 err_clear;

    modport master (
        output op_valid, pop_num, push_en, push_data, call_en, call_nargs, call_nlocals,
               ret_en, ret_nres, local_addr, local_set, local_set_data, err_clear,
        input  op_ready, local_get_data, pop_win, sp, fp, sb, frame_depth,
               err_underflow, err_overflow, err_frame
    );

    modport slave (
        input  op_valid, pop_num, push_en, push_data, call_en, call_nargs, call_nlocals,
               ret_en, ret_nres, local_addr, local_set, local_set_data, err_clear,
        output op_ready, local_get_data, pop_win, sp, fp, sb, frame_depth,
               err_underflow, err_overflow, err_frame
    );

endinterface

// File: rtl/wfs_frame_lifo.sv
// wfs_frame_lifo: register LIFO of saved call frames
//   clk, rst_n  : clock, asynchronous active-low reset (resets to empty)
//   push, din   : save din on top (ignored when full)
//   pop         : discard top (ignored when empty)
//   top         : most recently saved frame
//   depth       : live entries; full / empty flags
module wfs_frame_lifo
    import wasm_stack_pkg::*;
#(
    parameter int  FRAMES = 16,
    parameter type entry_t = frame_t
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  entry_t                      din,
    output entry_t                      top,
    output logic [fw_of(FRAMES)-1:0]    depth,
    output logic                        full,
    output logic                        empty
);
    localparam int FW = fw_of(FRAMES);
    localparam int IW = FRAMES > 1 ? $clog2(FRAMES) : 1;

    entry_t stack [FRAMES];

    assign full  = depth == FW'(FRAMES);
    assign empty = depth == '0;
    assign top   = stack[IW'(depth - FW'(1))];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            depth <= '0;
        else if (push && !full)
            depth <= depth + FW'(1);
        else if (pop && !empty)
            depth <= depth - FW'(1);

    always_ff @(posedge clk)
        if (push && !full)
            stack[IW'(depth)] <= din;

endmodule

// File: rtl/wasm_frame_stack.sv
// wasm_frame_stack: operand/locals stack with call-frame management for the WASM core
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wasm_frame_stack_if.slave (ops in; pop window, pointers, sticky errors out)
//   Optional WFS_BOUNDS_CHECK_EN: locals at or above sb-fp flag err_frame, suppress
//   local_set and read as 0; otherwise local addresses wrap mod DEPTH.
module wasm_frame_stack
    import wasm_stack_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int FRAMES = 16,
    parameter int WIN    = 3
) (
    input logic              clk,
    input logic              rst_n,
    wasm_frame_stack_if.slave bus
);
    localparam int AW = aw_of(DEPTH);
    localparam int FW = fw_of(FRAMES);

    typedef logic [AW:0] ptr_t;
    typedef struct packed {
        ptr_t fp;
        ptr_t sb;
    } frm_t;

    logic [WIDTH-1:0]     mem [DEPTH];
    state_e               state, state_n;
    ptr_t                 sp, fp, sb, cnt, len;
    ptr_t                 sp_n, fp_n, sb_n, cnt_n, len_n;
    logic                 e_uf, e_of, e_fr, set_uf, set_of, set_fr, clr;
    logic                 we, push_f, pop_f, full, empty, oob;
    logic [AW-1:0]        waddr, laddr;
    logic [WIDTH-1:0]     wdata;
    logic [FW-1:0]        depth;
    logic [WIN*WIDTH-1:0] win;
    frm_t                 top_f;
    int                   avail, nargs, nlocals, nres, npop;

    wfs_frame_lifo #(.FRAMES(FRAMES), .entry_t(frm_t)) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_f),
        .pop   (pop_f),
        .din   ('{fp: fp, sb: sb}),
        .top   (top_f),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // All checks are done in int so subtractions never wrap.
    assign avail   = int'(sp) - int'(sb);
    assign nargs   = int'(bus.call_nargs);
    assign nlocals = int'(bus.call_nlocals);
    assign nres    = int'(bus.ret_nres);
    assign npop    = int'(bus.pop_num);
    assign laddr   = AW'(fp + ptr_t'(bus.local_addr));
    assign clr     = bus.err_clear && state == IDLE;

`ifdef WFS_BOUNDS_CHECK_EN
    assign oob = int'(bus.local_addr) >= int'(sb) - int'(fp);
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        win = '0;
        for (int k = 0; k < WIN; k++)
            if (int'(sp) > int'(sb) + k)
                win[k*WIDTH +: WIDTH] = mem[AW'(int'(sp) - 1 - k)];
    end

    assign bus.op_ready       = state == IDLE;
    assign bus.local_get_data = oob ? '0 : mem[laddr];
    assign bus.pop_win        = win;
    assign bus.sp             = sp;
    assign bus.fp             = fp;
    assign bus.sb             = sb;
    assign bus.frame_depth    = depth;
    assign bus.err_underflow  = e_uf;
    assign bus.err_overflow   = e_of;
    assign bus.err_frame      = e_fr;

    always_comb begin
        state_n = state;
        sp_n    = sp;
        fp_n    = fp;
        sb_n    = sb;
        cnt_n   = cnt;
        len_n   = len;
        set_uf  = 1'b0;
        set_of  = 1'b0;
        set_fr  = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        push_f  = 1'b0;
        pop_f   = 1'b0;
        unique case (state)
            IDLE: if (bus.op_valid) begin
                if (bus.call_en && bus.ret_en) begin
                    set_fr = 1'b1;
                end else if (bus.ret_en) begin
                    set_fr = empty;
                    set_uf = nres > avail;
                    if (!set_fr && !set_uf) begin
                        state_n = RET_COPY;
                        cnt_n   = '0;
                        len_n   = ptr_t'(nres);
                    end
                end else if (bus.call_en) begin
                    set_fr = nargs > nlocals || full;
                    set_uf = nargs > avail;
                    set_of = int'(sp) - nargs + nlocals > DEPTH;
                    if (!set_fr && !set_uf && !set_of) begin
                        push_f  = 1'b1;
                        fp_n    = ptr_t'(int'(sp) - nargs);
                        sb_n    = ptr_t'(int'(sp) - nargs + nlocals);
                        state_n = ZERO;
                        cnt_n   = '0;
                        len_n   = ptr_t'(nlocals - nargs);
                    end
                end else if (bus.local_set) begin
                    set_fr = oob;
                    we     = !oob;
                    waddr  = laddr;
                    wdata  = bus.local_set_data;
                end else begin
                    set_uf = npop > avail;
                    set_of = int'(sp) - npop + int'(bus.push_en) > DEPTH;
                    if (!set_uf && !set_of) begin
                        sp_n  = ptr_t'(int'(sp) - npop + int'(bus.push_en));
                        we    = bus.push_en;
                        waddr = AW'(int'(sp) - npop);
                        wdata = bus.push_data;
                    end
                end
            end
            // Locals above the arguments start at the old sp, which is fp_new+nargs.
            ZERO: begin
                we    = len != '0;
                waddr = AW'(sp + cnt);
                cnt_n = cnt + ptr_t'(1);
                if (cnt_n >= len) begin
                    state_n = IDLE;
                    sp_n    = sb;
                end
            end
            // Ascending copy is safe because the destination never lies above the source.
            RET_COPY: begin
                we    = len != '0;
                waddr = AW'(fp + cnt);
                wdata = mem[AW'(sp - len + cnt)];
                cnt_n = cnt + ptr_t'(1);
                if (cnt_n >= len) begin
                    state_n = IDLE;
                    sp_n    = fp + len;
                    fp_n    = top_f.fp;
                    sb_n    = top_f.sb;
                    pop_f   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            sp    <= '0;
            fp    <= '0;
            sb    <= '0;
            cnt   <= '0;
            len   <= '0;
            e_uf  <= 1'b0;
            e_of  <= 1'b0;
            e_fr  <= 1'b0;
        end else begin
            state <= state_n;
            sp    <= sp_n;
            fp    <= fp_n;
            sb    <= sb_n;
            cnt   <= cnt_n;
            len   <= len_n;
            e_uf  <= set_uf | (e_uf & ~clr);
            e_of  <= set_of | (e_of & ~clr);
            e_fr  <= set_fr | (e_fr & ~clr);
        end

    always_ff @(posedge clk)
        if (we)
            mem[waddr] <= wdata;

endmodule

// File: tb/tb_wasm_frame_stack.sv
// tb_wasm_frame_stack: directed and randomized checks of wasm_frame_stack against a stack model
module tb_wasm_frame_stack;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int FRAMES = 4;
    localparam int WIN    = 3;
    localparam int AW     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wasm_frame_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES), .WIN(WIN)) bus ();

    wasm_frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES), .WIN(WIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    logic [WIDTH-1:0] m [DEPTH];
    int m_sp, m_fp, m_sb;
    int fq_fp[$], fq_sb[$];
    bit m_uf, m_of, m_fr;
    int got_busy, exp_busy;

    task automatic idle_inputs();
        bus.op_valid = 0; bus.pop_num = 0; bus.push_en = 0; bus.push_data = 0;
        bus.call_en = 0; bus.call_nargs = 0; bus.call_nlocals = 0;
        bus.ret_en = 0; bus.ret_nres = 0; bus.local_set = 0; bus.local_set_data = 0;
        bus.err_clear = 0;
    endtask

    task automatic model_reset();
        m_sp = 0; m_fp = 0; m_sb = 0;
        fq_fp.delete(); fq_sb.delete();
        m_uf = 0; m_of = 0; m_fr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.local_addr = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    // Whole-operation model: a call or return lands in one step; busy is the stall length.
    task automatic model_op(input int pn, input bit pe, input logic [WIDTH-1:0] pd,
                            input bit ce, input int na, input int nl,
                            input bit re, input int nr,
                            input bit ls, input int la, input logic [WIDTH-1:0] ld,
                            input bit clr, output int eb);
        bit su, so, sf;
        su = 0; so = 0; sf = 0; eb = 0;
        if (ce && re) sf = 1;
        else if (re) begin
            sf = fq_fp.size() == 0;
            su = nr > m_sp - m_sb;
            if (!sf && !su) begin
                for (int i = 0; i < nr; i++) m[m_fp + i] = m[m_sp - nr + i];
                m_sp = m_fp + nr;
                m_fp = fq_fp.pop_back();
                m_sb = fq_sb.pop_back();
                eb = nr == 0 ? 1 : nr;
            end
        end else if (ce) begin
            sf = na > nl || fq_fp.size() == FRAMES;
            su = na > m_sp - m_sb;
            so = m_sp - na + nl > DEPTH;
            if (!sf && !su && !so) begin
                fq_fp.push_back(m_fp);
                fq_sb.push_back(m_sb);
                for (int i = 0; i < nl - na; i++) m[m_sp + i] = 0;
                m_fp = m_sp - na;
                m_sb = m_fp + nl;
                m_sp = m_sb;
                eb = nl == na ? 1 : nl - na;
            end
        end else if (ls) m[(m_fp + la) % DEPTH] = ld;
        else begin
            su = pn > m_sp - m_sb;
            so = m_sp - pn + int'(pe) > DEPTH;
            if (!su && !so) begin
                if (pe) m[m_sp - pn] = pd;
                m_sp = m_sp - pn + int'(pe);
            end
        end
        m_uf = su | (m_uf & !clr);
        m_of = so | (m_of & !clr);
        m_fr = sf | (m_fr & !clr);
    endtask

    // Presents one op for one accepted cycle, then waits (bounded) for op_ready.
    task automatic drive_op(input int pn, input bit pe, input logic [WIDTH-1:0] pd,
                            input bit ce, input int na, input int nl,
                            input bit re, input int nr,
                            input bit ls, input int la, input logic [WIDTH-1:0] ld,
                            input bit clr);
        @(negedge clk);
        bus.op_valid = 1; bus.pop_num = 4'(pn); bus.push_en = pe; bus.push_data = pd;
        bus.call_en = ce; bus.call_nargs = 8'(na); bus.call_nlocals = 8'(nl);
        bus.ret_en = re; bus.ret_nres = 4'(nr);
        bus.local_set = ls; bus.local_addr = AW'(la); bus.local_set_data = ld;
        bus.err_clear = clr;
        model_op(pn, pe, pd, ce, na, nl, re, nr, ls, la, ld, clr, exp_busy);
        @(negedge clk);
        idle_inputs();
        got_busy = 0;
        while (!bus.op_ready && got_busy < 64) begin
            got_busy++;
            @(negedge clk);
        end
    endtask

    task automatic op_push(input logic [WIDTH-1:0] v);
        drive_op(0, 1, v, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.op_ready); end
        total++;
        if ({bus.sp, bus.fp, bus.sb} !== '0) begin bad++; $display("FAIL reset_ptrs: sp=%0d fp=%0d sb=%0d want 0", bus.sp, bus.fp, bus.sb); end
        total++;
        if ({bus.frame_depth, bus.err_underflow, bus.err_overflow, bus.err_frame} !== '0) begin
            bad++; $display("FAIL reset_flags: depth=%0d errs=%b%b%b want 0", bus.frame_depth, bus.err_underflow, bus.err_overflow, bus.err_frame);
        end
        total++;
        if (bus.pop_win !== '0) begin bad++; $display("FAIL reset_win: got %h want 0", bus.pop_win); end
    endtask

    task automatic test_push_pop();
        do_reset();
        op_push(5); op_push(7); op_push(9);
        #1;
        total++;
        if (bus.sp !== 3) begin bad++; $display("FAIL push3_sp: got %0d want 3", bus.sp); end
        total++;
        if (bus.pop_win !== {32'd5, 32'd7, 32'd9}) begin bad++; $display("FAIL push3_win: got %h want 5,7,9", bus.pop_win); end
        drive_op(2, 1, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.sp !== 2) begin bad++; $display("FAIL poppush_sp: got %0d want 2", bus.sp); end
        total++;
        if (bus.pop_win !== {32'd0, 32'd5, 32'd16}) begin bad++; $display("FAIL poppush_win: got %h want 0,5,16", bus.pop_win); end
        total++;
        if (got_busy !== 0) begin bad++; $display("FAIL poppush_busy: got %0d want 0", got_busy); end
    endtask

    task automatic test_underflow();
        do_reset();
        drive_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.err_underflow !== 1'b1 || bus.sp !== 0) begin bad++; $display("FAIL underflow: err=%b sp=%0d want 1,0", bus.err_underflow, bus.sp); end
        drive_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        total++;
        if (bus.err_underflow !== 1'b1) begin bad++; $display("FAIL set_beats_clear: got %b want 1", bus.err_underflow); end
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        total++;
        if (bus.err_underflow !== 1'b0) begin bad++; $display("FAIL clear: got %b want 0", bus.err_underflow); end
        op_push(3);
        drive_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.err_underflow !== 1'b0 || bus.sp !== 0) begin bad++; $display("FAIL pop_exact: err=%b sp=%0d want 0,0", bus.err_underflow, bus.sp); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) op_push(100 + i);
        #1;
        total++;
        if (bus.sp !== DEPTH || bus.err_overflow !== 1'b0) begin bad++; $display("FAIL fill: sp=%0d err=%b want %0d,0", bus.sp, bus.err_overflow, DEPTH); end
        op_push(77);
        #1;
        total++;
        if (bus.sp !== DEPTH || bus.err_overflow !== 1'b1) begin bad++; $display("FAIL overflow: sp=%0d err=%b want %0d,1", bus.sp, bus.err_overflow, DEPTH); end
        total++;
        if (bus.pop_win[WIDTH-1:0] !== 32'(100 + DEPTH - 1)) begin bad++; $display("FAIL overflow_keep: got %0d want %0d", bus.pop_win[WIDTH-1:0], 100 + DEPTH - 1); end
        drive_op(1, 1, 55, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        total++;
        if (bus.sp !== DEPTH || bus.err_overflow !== 1'b0 || bus.pop_win[WIDTH-1:0] !== 32'd55) begin
            bad++; $display("FAIL replace_top: sp=%0d err=%b top=%0d want %0d,0,55", bus.sp, bus.err_overflow, bus.pop_win[WIDTH-1:0], DEPTH);
        end
    endtask

    task automatic test_call_ret();
        logic [WIDTH-1:0] exp_l [4] = '{32'd2, 32'd3, 32'd0, 32'd0};
        do_reset();
        op_push(1); op_push(2); op_push(3);
        drive_op(0, 0, 0, 1, 2, 4, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (got_busy !== 2) begin bad++; $display("FAIL call_busy: got %0d want 2", got_busy); end
        total++;
        if (bus.fp !== 1 || bus.sb !== 5 || bus.sp !== 5 || bus.frame_depth !== 1) begin
            bad++; $display("FAIL call_ptrs: fp=%0d sb=%0d sp=%0d depth=%0d want 1,5,5,1", bus.fp, bus.sb, bus.sp, bus.frame_depth);
        end
        for (int i = 0; i < 4; i++) begin
            bus.local_addr = AW'(i);
            #1;
            total++;
            if (bus.local_get_data !== exp_l[i]) begin bad++; $display("FAIL local%0d: got %0d want %0d", i, bus.local_get_data, exp_l[i]); end
        end
        op_push(42);
        drive_op(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        #1;
        total++;
        if (got_busy !== 1) begin bad++; $display("FAIL ret_busy: got %0d want 1", got_busy); end
        total++;
        if (bus.sp !== 2 || bus.fp !== 0 || bus.sb !== 0 || bus.frame_depth !== 0) begin
            bad++; $display("FAIL ret_ptrs: sp=%0d fp=%0d sb=%0d depth=%0d want 2,0,0,0", bus.sp, bus.fp, bus.sb, bus.frame_depth);
        end
        total++;
        if (bus.pop_win !== {32'd0, 32'd1, 32'd42}) begin bad++; $display("FAIL ret_win: got %h want 0,1,42", bus.pop_win); end
    endtask

    task automatic test_frames();
        do_reset();
        for (int i = 0; i < FRAMES; i++) drive_op(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.frame_depth !== FRAMES || bus.err_frame !== 1'b0 || bus.sp !== FRAMES) begin
            bad++; $display("FAIL nest: depth=%0d err=%b sp=%0d want %0d,0,%0d", bus.frame_depth, bus.err_frame, bus.sp, FRAMES, FRAMES);
        end
        drive_op(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.frame_depth !== FRAMES || bus.err_frame !== 1'b1 || got_busy !== 0) begin
            bad++; $display("FAIL frame_full: depth=%0d err=%b busy=%0d want %0d,1,0", bus.frame_depth, bus.err_frame, got_busy, FRAMES);
        end
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < FRAMES; i++) drive_op(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.frame_depth !== 0 || bus.sp !== 0 || bus.err_frame !== 1'b0 || got_busy !== 1) begin
            bad++; $display("FAIL unwind: depth=%0d sp=%0d err=%b busy=%0d want 0,0,0,1", bus.frame_depth, bus.sp, bus.err_frame, got_busy);
        end
        drive_op(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.err_frame !== 1'b1) begin bad++; $display("FAIL ret_empty: got %b want 1", bus.err_frame); end
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        op_push(8);
        drive_op(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (bus.err_frame !== 1'b1 || bus.sp !== 1 || bus.frame_depth !== 0) begin
            bad++; $display("FAIL call_and_ret: err=%b sp=%0d depth=%0d want 1,1,0", bus.err_frame, bus.sp, bus.frame_depth);
        end
    endtask

    task automatic test_reset_mid_zero();
        do_reset();
        op_push(4);
        @(negedge clk);
        bus.op_valid = 1; bus.call_en = 1; bus.call_nargs = 1; bus.call_nlocals = 10;
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if (bus.op_ready !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", bus.op_ready); end
        rst_n = 0;
        #1;
        total++;
        if (bus.op_ready !== 1'b1 || {bus.sp, bus.fp, bus.sb} !== '0 || bus.frame_depth !== 0) begin
            bad++; $display("FAIL abort: ready=%b sp=%0d fp=%0d sb=%0d depth=%0d want 1,0,0,0,0", bus.op_ready, bus.sp, bus.fp, bus.sb, bus.frame_depth);
        end
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_random();
        int kind, pn, na, nl, nr, la;
        bit pe, clr;
        logic [WIDTH-1:0] ew;
        logic [WIN*WIDTH-1:0] ewin;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 99);
            clr = $urandom_range(0, 7) == 0;
            if (kind < 35) drive_op(0, 1, $urandom, 0, 0, 0, 0, 0, 0, 0, 0, clr);
            else if (kind < 65) begin
                pn = $urandom_range(0, 3);
                pe = 1'($urandom_range(0, 1));
                drive_op(pn, pe, $urandom, 0, 0, 0, 0, 0, 0, 0, 0, clr);
            end else if (kind < 76) begin
                na = $urandom_range(0, 3);
                nl = $urandom_range(0, 9) == 0 ? na - 1 : na + $urandom_range(0, 4);
                if (nl < 0) nl = 0;
                drive_op(0, 0, 0, 1, na, nl, 0, 0, 0, 0, 0, clr);
            end else if (kind < 88) drive_op(0, 0, 0, 0, 0, 0, 1, $urandom_range(0, 3), 0, 0, 0, clr);
            else if (kind < 96) drive_op(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom_range(0, DEPTH - 1), $urandom, clr);
            else drive_op(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, clr);
            ewin = '0;
            for (int k = 0; k < WIN; k++)
                if (m_sp - 1 - k >= m_sb) ewin[k*WIDTH +: WIDTH] = m[m_sp - 1 - k];
            #1;
            total++;
            if (got_busy !== exp_busy) begin bad++; $display("FAIL rnd%0d_busy: got %0d want %0d", it, got_busy, exp_busy); end
            total++;
            if (bus.sp !== (AW+1)'(m_sp) || bus.fp !== (AW+1)'(m_fp) || bus.sb !== (AW+1)'(m_sb) || bus.frame_depth !== 3'(fq_fp.size())) begin
                bad++; $display("FAIL rnd%0d_ptrs: sp/fp/sb/depth=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", it,
                                bus.sp, bus.fp, bus.sb, bus.frame_depth, m_sp, m_fp, m_sb, fq_fp.size());
            end
            total++;
            if ({bus.err_underflow, bus.err_overflow, bus.err_frame} !== {m_uf, m_of, m_fr}) begin
                bad++; $display("FAIL rnd%0d_errs: got %b%b%b want %b%b%b", it, bus.err_underflow, bus.err_overflow, bus.err_frame, m_uf, m_of, m_fr);
            end
            total++;
            if (bus.pop_win !== ewin) begin bad++; $display("FAIL rnd%0d_win: got %h want %h", it, bus.pop_win, ewin); end
            if (m_sp > m_fp) begin
                la = $urandom_range(0, m_sp - m_fp - 1);
                ew = m[m_fp + la];
                bus.local_addr = AW'(la);
                #1;
                total++;
                if (bus.local_get_data !== ew) begin bad++; $display("FAIL rnd%0d_local%0d: got %h want %h", it, la, bus.local_get_data, ew); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.local_addr = 0;
        test_reset();
        test_push_pop();
        test_underflow();
        test_overflow();
        test_call_ret();
        test_frames();
        test_reset_mid_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
